// File: rtl/cook_timer.sv
// -----------------------------------------------------------------------------
// cook_timer
// Keypad-entered BCD countdown timer (MM..MSS) with pause/resume/clear.
// Digit 0 = seconds ones, digit 1 = seconds tens, digits 2..N-1 = minutes.
// State machine: IDLE (key entry) -> RUN (countdown) <-> PAUSE, RUN -> DONE
// (one-cycle completion) -> IDLE. Every output is driven from a flop.
// -----------------------------------------------------------------------------
module cook_timer #(
    parameter int NUM_DIGITS    = 4,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic                    clk_1s,
    input  logic                    reset,
    input  logic                    digit_valid,
    input  logic [3:0]              digit_in,
    input  logic                    start,
    input  logic                    stop_clear,
    output logic [4*NUM_DIGITS-1:0] time_bcd,
    output logic                    running,
    output logic                    paused,
    output logic                    done,
    output logic                    entry_err
);

    localparam int TW = 4 * NUM_DIGITS;
    // Tick counter needs at least one bit even when every cycle is a tick.
    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] TICK_ONE  = CW'(1);
    localparam logic [CW-1:0] TICK_ZERO = CW'(0);
    localparam logic [TW-1:0] TIME_ZERO = TW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [TW-1:0]   time_r;
    logic [TW-1:0]   time_s;
    logic [CW-1:0]   tick_r;
    logic [CW-1:0]   tick_s;
    logic            err_s;
    logic [TW-1:0]   dec_s;

    logic            running_r;
    logic            paused_r;
    logic            done_r;
    logic            entry_err_r;
    logic            running_s;
    logic            paused_s;
    logic            done_s;

    // One-second BCD decrement. Seconds ones wrap to 9, seconds tens wrap to 5,
    // minute digits wrap to 9 while the borrow ripples upward. Seconds tens
    // above 5 are deliberately left as entered and simply count down.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] t);
        logic [TW-1:0] r;
        logic          borrow;
        logic [3:0]    wrap;
        r      = t;
        borrow = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            wrap = (k == 1) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (t[4*k +: 4] != 4'd0) begin
                    r[4*k +: 4] = t[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end else begin
                    r[4*k +: 4] = wrap;
                end
            end else begin
                r[4*k +: 4] = t[4*k +: 4];
            end
        end
        return r;
    endfunction

    assign dec_s = bcd_dec(time_r);

    // State, time and tick registers with synchronous reset.
    always_ff @(posedge clk_1s) begin
        if (reset) begin
            state_r <= ST_IDLE;
            time_r  <= TIME_ZERO;
            tick_r  <= TICK_ZERO;
        end else begin
            state_r <= state_s;
            time_r  <= time_s;
            tick_r  <= tick_s;
        end
    end

    // Next-state logic; within a cycle stop_clear beats start beats digit_valid.
    always_comb begin
        state_s = state_r;
        time_s  = time_r;
        tick_s  = tick_r;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tick_s = TICK_ZERO;
                if (stop_clear) begin
                    time_s = TIME_ZERO;
                end else if (start) begin
                    if (time_r != TIME_ZERO) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (digit_valid) begin
                    if (digit_in <= 4'd9) begin
                        time_s = {time_r[TW-5:0], digit_in};
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    time_s = time_r;
                end
            end
            ST_RUN: begin
                if (stop_clear) begin
                    state_s = ST_PAUSE;
                    tick_s  = TICK_ZERO;
                end else if (tick_r == TICK_LAST) begin
                    tick_s = TICK_ZERO;
                    time_s = dec_s;
                    if (dec_s == TIME_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    tick_s = tick_r + TICK_ONE;
                end
            end
            ST_PAUSE: begin
                tick_s = TICK_ZERO;
                if (stop_clear) begin
                    state_s = ST_IDLE;
                    time_s  = TIME_ZERO;
                end else if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                time_s  = TIME_ZERO;
                tick_s  = TICK_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
                time_s  = TIME_ZERO;
                tick_s  = TICK_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so the flops align with state_r.
    always_comb begin
        running_s = 1'b0;
        paused_s  = 1'b0;
        done_s    = 1'b0;
        case (state_s)
            ST_RUN:   running_s = 1'b1;
            ST_PAUSE: paused_s  = 1'b1;
            ST_DONE:  done_s    = 1'b1;
            default: begin
                running_s = 1'b0;
                paused_s  = 1'b0;
                done_s    = 1'b0;
            end
        endcase
    end

    // Output flags registered with synchronous reset.
    always_ff @(posedge clk_1s) begin
        if (reset) begin
            running_r   <= 1'b0;
            paused_r    <= 1'b0;
            done_r      <= 1'b0;
            entry_err_r <= 1'b0;
        end else begin
            running_r   <= running_s;
            paused_r    <= paused_s;
            done_r      <= done_s;
            entry_err_r <= err_s;
        end
    end

    assign time_bcd  = time_r;
    assign running   = running_r;
    assign paused    = paused_r;
    assign done      = done_r;
    assign entry_err = entry_err_r;

endmodule

// File: tb/tb_cook_timer.sv
// -----------------------------------------------------------------------------
// tb_cook_timer
// Directed bench for cook_timer. Three instances share one stimulus stream:
// u_t1 (4 digits, 1 tick/s), u_t4 (4 digits, 4 ticks/s), u_w6 (6 digits).
// -----------------------------------------------------------------------------
module tb_cook_timer;

    logic        clk_1s;
    logic        reset;
    logic        digit_valid;
    logic [3:0]  digit_in;
    logic        start;
    logic        stop_clear;

    logic [15:0] t1_time;
    logic        t1_run, t1_pau, t1_done, t1_err;
    logic [15:0] t4_time;
    logic        t4_run, t4_pau, t4_done, t4_err;
    logic [23:0] w6_time;
    logic        w6_run, w6_pau, w6_done, w6_err;

    int checks   = 0;
    int failures = 0;

    cook_timer #(.NUM_DIGITS(4), .TICKS_PER_SEC(1)) u_t1 (
        .clk_1s(clk_1s), .reset(reset), .digit_valid(digit_valid),
        .digit_in(digit_in), .start(start), .stop_clear(stop_clear),
        .time_bcd(t1_time), .running(t1_run), .paused(t1_pau),
        .done(t1_done), .entry_err(t1_err)
    );

    cook_timer #(.NUM_DIGITS(4), .TICKS_PER_SEC(4)) u_t4 (
        .clk_1s(clk_1s), .reset(reset), .digit_valid(digit_valid),
        .digit_in(digit_in), .start(start), .stop_clear(stop_clear),
        .time_bcd(t4_time), .running(t4_run), .paused(t4_pau),
        .done(t4_done), .entry_err(t4_err)
    );

    cook_timer #(.NUM_DIGITS(6), .TICKS_PER_SEC(1)) u_w6 (
        .clk_1s(clk_1s), .reset(reset), .digit_valid(digit_valid),
        .digit_in(digit_in), .start(start), .stop_clear(stop_clear),
        .time_bcd(w6_time), .running(w6_run), .paused(w6_pau),
        .done(w6_done), .entry_err(w6_err)
    );

    initial clk_1s = 1'b0;
    always #5 clk_1s = ~clk_1s;

    // One clock: outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk_1s);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        cyc();
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (t1_time !== 16'h0000) begin failures++; $display("FAIL reset_time got=%h exp=0000", t1_time); end
        checks++;
        if ({t1_run, t1_pau, t1_done, t1_err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {t1_run, t1_pau, t1_done, t1_err});
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (t1_run !== 1'b0) begin failures++; $display("FAIL start_on_zero got=%b exp=0", t1_run); end
    endtask

    task automatic test_key_entry();
        do_reset();
        key(4'd1); key(4'd2); key(4'd3); key(4'd0);
        checks++;
        if (t1_time !== 16'h1230) begin failures++; $display("FAIL key_1230 got=%h exp=1230", t1_time); end
        key(4'd4);
        checks++;
        if (t1_time !== 16'h2304) begin failures++; $display("FAIL key_shift got=%h exp=2304", t1_time); end
        checks++;
        if (t1_err !== 1'b0) begin failures++; $display("FAIL key_no_err got=%b exp=0", t1_err); end
        key(4'hA);
        checks++;
        if (t1_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", t1_err); end
        checks++;
        if (t1_time !== 16'h2304) begin failures++; $display("FAIL err_hold got=%h exp=2304", t1_time); end
        cyc();
        checks++;
        if (t1_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got=%b exp=0", t1_err); end
        stop_clear = 1'b1;
        cyc();
        stop_clear = 1'b0;
        checks++;
        if (t1_time !== 16'h0000) begin failures++; $display("FAIL idle_clear got=%h exp=0000", t1_time); end
    endtask

    task automatic test_borrow();
        do_reset();
        key(4'd0); key(4'd1); key(4'd0); key(4'd0);
        press_start();
        checks++;
        if (t1_run !== 1'b1 || t1_time !== 16'h0100) begin
            failures++; $display("FAIL run_entry got=%b/%h exp=1/0100", t1_run, t1_time);
        end
        cyc();
        checks++;
        if (t1_time !== 16'h0059) begin failures++; $display("FAIL borrow_0059 got=%h exp=0059", t1_time); end
        cyc();
        checks++;
        if (t1_time !== 16'h0058) begin failures++; $display("FAIL borrow_0058 got=%h exp=0058", t1_time); end
        // keys and start are ignored while running
        digit_valid = 1'b1;
        digit_in    = 4'hF;
        start       = 1'b1;
        cyc();
        digit_valid = 1'b0;
        start       = 1'b0;
        checks++;
        if (t1_time !== 16'h0057 || t1_err !== 1'b0) begin
            failures++; $display("FAIL run_ignore got=%h/%b exp=0057/0", t1_time, t1_err);
        end
        // minute-digit borrow 10:00 -> 09:59
        do_reset();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        press_start();
        cyc();
        checks++;
        if (t1_time !== 16'h0959) begin failures++; $display("FAIL borrow_0959 got=%h exp=0959", t1_time); end
        // unnormalised seconds tens 90 -> 89
        do_reset();
        key(4'd9); key(4'd0);
        press_start();
        cyc();
        checks++;
        if (t1_time !== 16'h0089) begin failures++; $display("FAIL tens90 got=%h exp=0089", t1_time); end
    endtask

    task automatic test_done();
        do_reset();
        key(4'd3);
        press_start();
        cyc();
        checks++;
        if (t1_time !== 16'h0002) begin failures++; $display("FAIL done_0002 got=%h exp=0002", t1_time); end
        cyc();
        checks++;
        if (t1_time !== 16'h0001 || t1_done !== 1'b0) begin
            failures++; $display("FAIL done_0001 got=%h/%b exp=0001/0", t1_time, t1_done);
        end
        cyc();
        checks++;
        if (t1_done !== 1'b1 || t1_time !== 16'h0000 || t1_run !== 1'b0) begin
            failures++; $display("FAIL done_pulse got=%b/%h/%b exp=1/0000/0", t1_done, t1_time, t1_run);
        end
        cyc();
        checks++;
        if (t1_done !== 1'b0 || t1_time !== 16'h0000 || t1_run !== 1'b0) begin
            failures++; $display("FAIL done_idle got=%b/%h/%b exp=0/0000/0", t1_done, t1_time, t1_run);
        end
    endtask

    task automatic test_back_to_back();
        // IDLE after DONE accepts keys and a new run immediately
        key(4'd1);
        checks++;
        if (t1_time !== 16'h0001) begin failures++; $display("FAIL b2b_key got=%h exp=0001", t1_time); end
        press_start();
        cyc();
        checks++;
        if (t1_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", t1_done); end
    endtask

    task automatic test_pause();
        do_reset();
        key(4'd1); key(4'd0);
        press_start();
        checks++;
        if (t4_run !== 1'b1 || t4_time !== 16'h0010) begin
            failures++; $display("FAIL p_run got=%b/%h exp=1/0010", t4_run, t4_time);
        end
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (i == 3) begin
                checks++;
                if (t4_time !== 16'h0010) begin failures++; $display("FAIL p_pre_tick got=%h exp=0010", t4_time); end
            end
            if (i == 4) begin
                checks++;
                if (t4_time !== 16'h0009) begin failures++; $display("FAIL p_tick4 got=%h exp=0009", t4_time); end
            end
        end
        stop_clear = 1'b1;
        cyc();
        stop_clear = 1'b0;
        checks++;
        if (t4_pau !== 1'b1 || t4_run !== 1'b0 || t4_time !== 16'h0009) begin
            failures++; $display("FAIL p_pause got=%b/%b/%h exp=1/0/0009", t4_pau, t4_run, t4_time);
        end
        key(4'hB);
        cyc();
        checks++;
        if (t4_time !== 16'h0009 || t4_err !== 1'b0 || t4_pau !== 1'b1) begin
            failures++; $display("FAIL p_hold got=%h/%b/%b exp=0009/0/1", t4_time, t4_err, t4_pau);
        end
        press_start();
        checks++;
        if (t4_run !== 1'b1 || t4_pau !== 1'b0) begin
            failures++; $display("FAIL p_resume got=%b/%b exp=1/0", t4_run, t4_pau);
        end
        cyc(); cyc(); cyc();
        checks++;
        if (t4_time !== 16'h0009) begin failures++; $display("FAIL p_resume3 got=%h exp=0009", t4_time); end
        cyc();
        checks++;
        if (t4_time !== 16'h0008) begin failures++; $display("FAIL p_resume4 got=%h exp=0008", t4_time); end
        stop_clear = 1'b1;
        cyc();
        checks++;
        if (t4_pau !== 1'b1) begin failures++; $display("FAIL p_pause2 got=%b exp=1", t4_pau); end
        cyc();
        stop_clear = 1'b0;
        checks++;
        if (t4_time !== 16'h0000 || t4_pau !== 1'b0 || t4_run !== 1'b0) begin
            failures++; $display("FAIL p_clear got=%h/%b/%b exp=0000/0/0", t4_time, t4_pau, t4_run);
        end
    endtask

    task automatic test_priority();
        do_reset();
        key(4'd5);
        start      = 1'b1;
        stop_clear = 1'b1;
        cyc();
        start      = 1'b0;
        stop_clear = 1'b0;
        checks++;
        if (t1_time !== 16'h0000 || t1_run !== 1'b0) begin
            failures++; $display("FAIL prio_stop got=%h/%b exp=0000/0", t1_time, t1_run);
        end
        key(4'd5);
        start       = 1'b1;
        digit_valid = 1'b1;
        digit_in    = 4'd7;
        cyc();
        start       = 1'b0;
        digit_valid = 1'b0;
        checks++;
        if (t1_time !== 16'h0005 || t1_run !== 1'b1) begin
            failures++; $display("FAIL prio_start got=%h/%b exp=0005/1", t1_time, t1_run);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        key(4'd4); key(4'd2);
        press_start();
        cyc();
        checks++;
        if (t1_time !== 16'h0041) begin failures++; $display("FAIL mr_0041 got=%h exp=0041", t1_time); end
        reset = 1'b1;
        start = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if ({t1_time, t1_run, t1_pau, t1_done, t1_err} !== 20'h00000) begin
            failures++; $display("FAIL mr_reset got=%h/%b%b%b%b exp=0000/0000", t1_time, t1_run, t1_pau, t1_done, t1_err);
        end
        for (int i = 0; i < 50; i++) begin
            cyc();
            checks++;
            if (t1_done !== 1'b0 || t1_run !== 1'b0) begin
                failures++; $display("FAIL mr_no_done got=%b/%b exp=0/0", t1_done, t1_run);
            end
        end
    endtask

    task automatic test_width6();
        do_reset();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0); key(4'd0); key(4'd0);
        checks++;
        if (w6_time !== 24'h100000) begin failures++; $display("FAIL w6_entry got=%h exp=100000", w6_time); end
        press_start();
        cyc();
        checks++;
        if (w6_time !== 24'h099959) begin failures++; $display("FAIL w6_dec got=%h exp=099959", w6_time); end
    endtask

    initial begin
        reset       = 1'b1;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        test_reset();
        test_key_entry();
        test_borrow();
        test_done();
        test_back_to_back();
        test_pause();
        test_priority();
        test_reset_mid_run();
        test_width6();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
